// File: rtl/uart_rx_if.sv
// Output handshake bundle of the parametrised UART receiver: word, per-frame flags, overrun pulse.
// The receiver drives it through the master modport; the byte consumer uses the slave modport.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output out_data,
    output out_valid,
    output parity_err,
    output frame_err,
    output overrun,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  parity_err,
    input  frame_err,
    input  overrun,
    output out_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver: edge-qualified start, mid-bit alignment,
// 3-sample majority vote per bit, optional runtime parity, 1 or 2 stop bits, valid/ready output.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         baud_tick,
  input  logic         rx,
  input  logic         parity_en,
  input  logic         parity_odd,
  output logic         busy,
  uart_rx_if.master    out_if
);

  localparam int TCNT_W = $clog2(OVERSAMPLE);
  localparam int BCNT_W = $clog2(DATA_BITS + 1);

  localparam logic [TCNT_W-1:0] T_MID  = TCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TCNT_W-1:0] T_S0   = TCNT_W'(OVERSAMPLE - 3);
  localparam logic [TCNT_W-1:0] T_S1   = TCNT_W'(OVERSAMPLE - 2);
  localparam logic [TCNT_W-1:0] T_LAST = TCNT_W'(OVERSAMPLE - 1);

  localparam logic [BCNT_W-1:0] B_DATA_LAST = BCNT_W'(DATA_BITS - 1);
  localparam logic [BCNT_W-1:0] B_STOP_LAST = BCNT_W'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic                 rx_m_q, rx_m_d;
  logic                 rx_s_q, rx_s_d;
  logic                 rx_dly_q, rx_dly_d;
  logic [2:0]           state_q, state_d;
  logic [TCNT_W-1:0]    tcnt_q, tcnt_d;
  logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_en_q, par_en_d;
  logic                 par_odd_q, par_odd_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 overrun_q, overrun_d;

  logic bit_val;
  logic publish;

  always_comb begin
    rx_m_d      = rx;
    rx_s_d      = rx_m_q;
    rx_dly_d    = rx_s_q;
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    bcnt_d      = bcnt_q;
    smp_d       = smp_q;
    shift_d     = shift_q;
    par_en_d    = par_en_q;
    par_odd_d   = par_odd_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    perr_out_d  = perr_out_q;
    ferr_out_d  = ferr_out_q;
    overrun_d   = 1'b0;
    publish     = 1'b0;
    bit_val     = majority3(smp_q[0], smp_q[1], rx_s_q);

    case (state_q)
      S_IDLE: begin
        // Only a genuine 1->0 transition starts a frame; a line that is already low is ignored.
        if (rx_dly_q && !rx_s_q) begin
          state_d   = S_START;
          tcnt_d    = '0;
          bcnt_d    = '0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
          par_en_d  = parity_en;
          par_odd_d = parity_odd;
        end
      end
      S_START: begin
        if (baud_tick) begin
          if (tcnt_q == T_MID) begin
            tcnt_d  = '0;
            state_d = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end
      S_DATA, S_PARITY, S_STOP: begin
        if (baud_tick) begin
          if (tcnt_q == T_S0) smp_d[0] = rx_s_q;
          if (tcnt_q == T_S1) smp_d[1] = rx_s_q;
          tcnt_d = (tcnt_q == T_LAST) ? '0 : tcnt_q + TCNT_W'(1);
          if (tcnt_q == T_LAST) begin
            if (state_q == S_DATA) begin
              shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
              if (bcnt_q == B_DATA_LAST) begin
                bcnt_d  = '0;
                state_d = par_en_q ? S_PARITY : S_STOP;
              end else begin
                bcnt_d = bcnt_q + BCNT_W'(1);
              end
            end else if (state_q == S_PARITY) begin
              perr_d  = ((^shift_q) ^ bit_val) != par_odd_q;
              state_d = S_STOP;
            end else begin
              if (!bit_val) ferr_d = 1'b1;
              if (bcnt_q == B_STOP_LAST) begin
                bcnt_d  = '0;
                publish = 1'b1;
                state_d = S_IDLE;
              end else begin
                bcnt_d = bcnt_q + BCNT_W'(1);
              end
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A publish either lands in the output register or is dropped with an overrun pulse.
    if (publish) begin
      if (!out_valid_q || out_if.out_ready) begin
        out_data_d  = shift_q;
        perr_out_d  = perr_q;
        ferr_out_d  = ferr_q | ~bit_val;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_if.out_ready) begin
      out_valid_d = 1'b0;
      perr_out_d  = 1'b0;
      ferr_out_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_m_q      <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_dly_q    <= 1'b1;
      state_q     <= S_IDLE;
      tcnt_q      <= '0;
      bcnt_q      <= '0;
      smp_q       <= '0;
      shift_q     <= '0;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      perr_out_q  <= 1'b0;
      ferr_out_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_m_q      <= rx_m_d;
      rx_s_q      <= rx_s_d;
      rx_dly_q    <= rx_dly_d;
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      bcnt_q      <= bcnt_d;
      smp_q       <= smp_d;
      shift_q     <= shift_d;
      par_en_q    <= par_en_d;
      par_odd_q   <= par_odd_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      perr_out_q  <= perr_out_d;
      ferr_out_q  <= ferr_out_d;
      overrun_q   <= overrun_d;
    end
  end

  assign busy              = (state_q != S_IDLE);
  assign out_if.out_data   = out_data_q;
  assign out_if.out_valid  = out_valid_q;
  assign out_if.parity_err = perr_out_q;
  assign out_if.frame_err  = ferr_out_q;
  assign out_if.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param (8 data bits, 16x oversample, 1 stop bit).
// Baud tick every 4 clocks; line driven on the falling clock edge just ahead of a tick.
module tb_uart_rx_param;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int STOP_BITS  = 1;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic parity_en;
  logic parity_odd;
  logic busy;
  logic baud_tick;
  logic [1:0] div = 2'd0;

  uart_rx_if #(.DATA_BITS(DATA_BITS)) ifc ();

  uart_rx_param #(
    .DATA_BITS (DATA_BITS),
    .OVERSAMPLE(OVERSAMPLE),
    .STOP_BITS (STOP_BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .rx        (rx),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .busy      (busy),
    .out_if    (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) div <= div + 2'd1;
  assign baud_tick = (div == 2'd3);

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vld_rises = 0;
  int   ovr_cnt   = 0;
  logic vld_prev  = 1'b0;

  always @(negedge clk) begin
    if (ifc.out_valid && !vld_prev) vld_rises++;
    vld_prev = ifc.out_valid;
    if (ifc.overrun === 1'b1) ovr_cnt++;
  end

  initial begin
    #800us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [7:0] d, input bit has_par, input bit pbit,
                                 input bit odd, input bit stop_bit);
    exp_t e;
    e.d  = d;
    e.pe = has_par && (((^d) ^ pbit) != odd);
    e.fe = !stop_bit;
    return e;
  endfunction

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(negedge clk);
      while (!baud_tick) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit has_par, input bit pbit,
                            input bit stop_bit, input bit glitch);
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(OVERSAMPLE);
    for (int i = 0; i < DATA_BITS; i++) begin
      rx = d[i];
      if (glitch) begin
        wait_ticks(6);
        rx = ~d[i];
        wait_ticks(1);
        rx = d[i];
        wait_ticks(OVERSAMPLE - 7);
      end else begin
        wait_ticks(OVERSAMPLE);
      end
    end
    if (has_par) begin
      rx = pbit;
      wait_ticks(OVERSAMPLE);
    end
    rx = stop_bit;
    wait_ticks(OVERSAMPLE);
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (ifc.out_valid !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    ok = (ifc.out_valid === 1'b1);
  endtask

  task automatic do_accept();
    @(negedge clk);
    ifc.out_ready = 1'b1;
    @(negedge clk);
    ifc.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rx = 1'b1;
    parity_en = 1'b0;
    parity_odd = 1'b0;
    ifc.out_ready = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({ifc.out_valid, ifc.parity_err, ifc.frame_err, ifc.overrun, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got v/pe/fe/ovr/busy=%b required 00000",
               {ifc.out_valid, ifc.parity_err, ifc.frame_err, ifc.overrun, busy});
    end
    n_checks++;
    if (ifc.out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 00", ifc.out_data);
    end
    rst = 1'b1;
    wait_ticks(4);
  endtask

  task automatic test_basic();
    logic [7:0] pats [4] = '{8'hA5, 8'h00, 8'hFF, 8'h81};
    exp_t e;
    bit   ok;
    foreach (pats[k]) begin
      sb_q.push_back(model(pats[k], 0, 0, 0, 1));
      send_frame(pats[k], 0, 0, 1, 0);
      wait_valid(ok);
      n_checks++;
      if (!ok || sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL basic_valid: got out_valid=%b required 1 (word %h)", ifc.out_valid, pats[k]);
      end else begin
        e = sb_q.pop_front();
        n_checks++;
        if ({ifc.out_data, ifc.parity_err, ifc.frame_err} !== e) begin
          n_fail++;
          $display("FAIL basic_word: got %h pe=%b fe=%b required %h pe=%b fe=%b",
                   ifc.out_data, ifc.parity_err, ifc.frame_err, e.d, e.pe, e.fe);
        end
      end
      do_accept();
      n_checks++;
      if (ifc.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_accept: got out_valid=%b required 0", ifc.out_valid);
      end
    end
  endtask

  task automatic test_parity();
    logic [7:0] d = 8'h3C;
    bit   pb   [3] = '{1'b1, 1'b0, 1'b0};
    bit   oddv [3] = '{1'b0, 1'b0, 1'b1};
    exp_t e;
    bit   ok;
    parity_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      parity_odd = oddv[k];
      sb_q.push_back(model(d, 1, pb[k], oddv[k], 1));
      send_frame(d, 1, pb[k], 1, 0);
      wait_valid(ok);
      n_checks++;
      if (!ok || sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL parity_valid: got out_valid=%b required 1 (case %0d)", ifc.out_valid, k);
      end else begin
        e = sb_q.pop_front();
        n_checks++;
        if ({ifc.out_data, ifc.parity_err, ifc.frame_err} !== e) begin
          n_fail++;
          $display("FAIL parity_word case %0d: got %h pe=%b fe=%b required %h pe=%b fe=%b",
                   k, ifc.out_data, ifc.parity_err, ifc.frame_err, e.d, e.pe, e.fe);
        end
      end
      do_accept();
    end
    parity_en = 1'b0;
    parity_odd = 1'b0;
  endtask

  task automatic test_frame_err();
    exp_t e;
    bit   ok;
    int   rises0;
    sb_q.push_back(model(8'h55, 0, 0, 0, 0));
    send_frame(8'h55, 0, 0, 0, 0);
    wait_valid(ok);
    n_checks++;
    if (!ok || sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL ferr_valid: got out_valid=%b required 1", ifc.out_valid);
    end else begin
      e = sb_q.pop_front();
      n_checks++;
      if ({ifc.out_data, ifc.parity_err, ifc.frame_err} !== e) begin
        n_fail++;
        $display("FAIL ferr_word: got %h pe=%b fe=%b required %h pe=%b fe=%b",
                 ifc.out_data, ifc.parity_err, ifc.frame_err, e.d, e.pe, e.fe);
      end
    end
    do_accept();
    rises0 = vld_rises;
    wait_ticks(4 * OVERSAMPLE);
    n_checks++;
    if (busy !== 1'b0 || vld_rises != rises0) begin
      n_fail++;
      $display("FAIL ferr_stuck_low: got busy=%b new_frames=%0d required busy=0 new_frames=0",
               busy, vld_rises - rises0);
    end
    rx = 1'b1;
    wait_ticks(4);
  endtask

  task automatic test_false_start();
    int rises0 = vld_rises;
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL false_start_busy: got busy=%b required 1", busy);
    end
    wait_ticks(8);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL false_start_idle: got busy=%b required 0", busy);
    end
    wait_ticks(2 * OVERSAMPLE);
    n_checks++;
    if (vld_rises != rises0) begin
      n_fail++;
      $display("FAIL false_start_output: got %0d frames required 0", vld_rises - rises0);
    end
  endtask

  task automatic test_overrun();
    exp_t e;
    bit   ok;
    int   ovr0 = ovr_cnt;
    ifc.out_ready = 1'b0;
    sb_q.push_back(model(8'h11, 0, 0, 0, 1));
    send_frame(8'h11, 0, 0, 1, 0);
    send_frame(8'h22, 0, 0, 1, 0);
    wait_ticks(2);
    n_checks++;
    if (ovr_cnt - ovr0 != 1) begin
      n_fail++;
      $display("FAIL overrun_pulse: got %0d pulse clocks required 1", ovr_cnt - ovr0);
    end
    wait_valid(ok);
    n_checks++;
    if (!ok || sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL overrun_valid: got out_valid=%b required 1", ifc.out_valid);
    end else begin
      e = sb_q.pop_front();
      n_checks++;
      if ({ifc.out_data, ifc.parity_err, ifc.frame_err} !== e) begin
        n_fail++;
        $display("FAIL overrun_held: got %h pe=%b fe=%b required %h pe=%b fe=%b",
                 ifc.out_data, ifc.parity_err, ifc.frame_err, e.d, e.pe, e.fe);
      end
    end
    do_accept();
  endtask

  task automatic test_glitch_reset();
    exp_t e;
    bit   ok;
    sb_q.push_back(model(8'h0F, 0, 0, 0, 1));
    send_frame(8'h0F, 0, 0, 1, 1);
    wait_valid(ok);
    n_checks++;
    if (!ok || sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL glitch_valid: got out_valid=%b required 1", ifc.out_valid);
    end else begin
      e = sb_q.pop_front();
      n_checks++;
      if ({ifc.out_data, ifc.parity_err, ifc.frame_err} !== e) begin
        n_fail++;
        $display("FAIL glitch_word: got %h pe=%b fe=%b required %h pe=%b fe=%b",
                 ifc.out_data, ifc.parity_err, ifc.frame_err, e.d, e.pe, e.fe);
      end
    end
    do_accept();
    // Abandon a frame three data bits in.
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(4 * OVERSAMPLE);
    @(negedge clk);
    rst = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, ifc.out_valid, ifc.out_data} !== 10'b0) begin
      n_fail++;
      $display("FAIL midframe_reset: got busy=%b v=%b data=%h required 0 0 00",
               busy, ifc.out_valid, ifc.out_data);
    end
    rst = 1'b1;
    wait_ticks(8);
    sb_q.push_back(model(8'hC3, 0, 0, 0, 1));
    send_frame(8'hC3, 0, 0, 1, 0);
    wait_valid(ok);
    n_checks++;
    if (!ok || sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL post_reset_valid: got out_valid=%b required 1", ifc.out_valid);
    end else begin
      e = sb_q.pop_front();
      n_checks++;
      if ({ifc.out_data, ifc.parity_err, ifc.frame_err} !== e) begin
        n_fail++;
        $display("FAIL post_reset_word: got %h pe=%b fe=%b required %h pe=%b fe=%b",
                 ifc.out_data, ifc.parity_err, ifc.frame_err, e.d, e.pe, e.fe);
      end
    end
    do_accept();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_false_start();
    test_overrun();
    test_glitch_reset();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
